rf2d_seq: RTL and testbench

- Frame sequencer for the 2-D row/column-shift register file of the convolution engine.
- Drives the file's reset, colShift, rowShift and row-data inputs.
- Accepts image rows from upstream through a valid/ready handshake.
- Qualifies the file's res pixel stream for downstream with px_valid/px_ready and row/column position flags.

---
 rtl/rf2d_seq.sv | 195 +++++++++++++++++++
 tb/tb_rf2d_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf2d_seq.sv
// rf2d_seq: frame sequencer for the 2-D row/column-shift register file.
// It clears the file, fills it with NUM_ROW rows (upstream rows, then zero
// flushes), scans each row out pixel by pixel through column rotation, and
// advances one row between scans until every frame row has been delivered.
// Optional build macro: RF2D_SEQ_PERF_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
module rf2d_seq #(
  parameter int NUM_ROW  = 16,
  parameter int NUM_COL  = 18,
  parameter int NUM_BITS = 10,
  parameter int FR_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [FR_W-1:0]              frame_rows,
  input  logic [NUM_COL*NUM_BITS-1:0]  row_data,
  input  logic                         row_valid,
  output logic                         row_ready,
  output logic                         rf_reset,
  output logic                         rf_colShift,
  output logic                         rf_rowShift,
  output logic [NUM_COL*NUM_BITS-1:0]  rf_data,
  output logic                         px_valid,
  input  logic                         px_ready,
  output logic                         px_last_col,
  output logic                         px_last_row,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  stall_cycles
);

  localparam int FC_W = $clog2(NUM_ROW + 1);
  localparam int CC_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_SCAN,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [FR_W-1:0]   row_in_cnt_q, row_in_cnt_d;
  logic [FR_W-1:0]   row_out_cnt_q, row_out_cnt_d;
  logic [CC_W-1:0]   col_cnt_q, col_cnt_d;
  logic [FR_W-1:0]   frame_rows_q, frame_rows_d;

  logic              need_row;
  logic              at_last_col;
  logic              at_last_row;
  logic              row_step;

  // Rows still owed by upstream decide between a handshake shift and a zero flush.
  assign need_row    = (row_in_cnt_q < frame_rows_q);
  assign at_last_col = (col_cnt_q == CC_W'(NUM_COL - 1));
  assign at_last_row = (row_out_cnt_q == (frame_rows_q - FR_W'(1)));
  assign busy        = (state_q != S_IDLE);

  // State and counter registers; everything returns to idle/zero on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fill_cnt_q    <= '0;
      row_in_cnt_q  <= '0;
      row_out_cnt_q <= '0;
      col_cnt_q     <= '0;
      frame_rows_q  <= '0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      row_in_cnt_q  <= row_in_cnt_d;
      row_out_cnt_q <= row_out_cnt_d;
      col_cnt_q     <= col_cnt_d;
      frame_rows_q  <= frame_rows_d;
    end
  end

  // Next-state, counter updates and register-file controls.
  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    row_in_cnt_d  = row_in_cnt_q;
    row_out_cnt_d = row_out_cnt_q;
    col_cnt_d     = col_cnt_q;
    frame_rows_d  = frame_rows_q;
    row_ready     = 1'b0;
    rf_reset      = 1'b0;
    rf_colShift   = 1'b0;
    rf_rowShift   = 1'b0;
    rf_data       = '0;
    px_valid      = 1'b0;
    px_last_col   = 1'b0;
    px_last_row   = 1'b0;
    done          = 1'b0;
    row_step      = 1'b0;

    // One row shift for FILL and ADVANCE: take an upstream row while any are
    // owed (stalling without row_valid), otherwise shift in zeros.
    if (state_q == S_FILL || state_q == S_ADVANCE) begin
      if (need_row) begin
        row_ready = 1'b1;
        if (row_valid) begin
          rf_rowShift  = 1'b1;
          rf_data      = row_data;
          row_in_cnt_d = row_in_cnt_q + FR_W'(1);
          row_step     = 1'b1;
        end
      end else begin
        rf_rowShift = 1'b1;
        row_step    = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frame_rows_d  = frame_rows;
          fill_cnt_d    = '0;
          row_in_cnt_d  = '0;
          row_out_cnt_d = '0;
          col_cnt_d     = '0;
          state_d       = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rf_reset = 1'b1;
        state_d  = (frame_rows_q == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        if (row_step) begin
          fill_cnt_d = fill_cnt_q + FC_W'(1);
          if (fill_cnt_q == FC_W'(NUM_ROW - 1)) begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        px_valid    = 1'b1;
        px_last_col = at_last_col;
        px_last_row = at_last_row;
        if (px_ready) begin
          rf_colShift = 1'b1;
          if (at_last_col) begin
            // A full rotation restores row 0 alignment; the row is finished.
            col_cnt_d     = '0;
            row_out_cnt_d = row_out_cnt_q + FR_W'(1);
            state_d       = at_last_row ? S_DONE : S_ADVANCE;
          end else begin
            col_cnt_d = col_cnt_q + CC_W'(1);
          end
        end
      end
      S_ADVANCE: begin
        if (row_step) begin
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef RF2D_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = (((state_q == S_FILL) || (state_q == S_ADVANCE)) && need_row && !row_valid)
                  || ((state_q == S_SCAN) && !px_ready);

  // Saturating count of cycles lost to upstream starvation or downstream back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (stall_ev && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rf2d_seq.sv
// Testbench for rf2d_seq: scoreboard of expected row-shift data and pixel
// position flags, filled when a frame is started and drained as the DUT
// shifts rows and hands pixels downstream.
module tb_rf2d_seq;

  localparam int NR    = 16;
  localparam int NC    = 18;
  localparam int NB    = 10;
  localparam int FRW   = 16;
  localparam int ROW_W = NC * NB;
  localparam int BOUND = 3000;

  logic             clk;
  logic             reset;
  logic             start;
  logic [FRW-1:0]   frame_rows;
  logic [ROW_W-1:0] row_data;
  logic             row_valid;
  logic             row_ready;
  logic             rf_reset;
  logic             rf_colShift;
  logic             rf_rowShift;
  logic [ROW_W-1:0] rf_data;
  logic             px_valid;
  logic             px_ready;
  logic             px_last_col;
  logic             px_last_row;
  logic             busy;
  logic             done;
  logic [31:0]      stall_cycles;

  rf2d_seq #(.NUM_ROW(NR), .NUM_COL(NC), .NUM_BITS(NB), .FR_W(FRW)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_rows(frame_rows),
    .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
    .rf_reset(rf_reset), .rf_colShift(rf_colShift), .rf_rowShift(rf_rowShift),
    .rf_data(rf_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_last_col(px_last_col), .px_last_row(px_last_row), .busy(busy),
    .done(done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Per-frame observations gathered by run_frame.
  int first_px, done_cyc, n_done, n_px, n_rst, n_acc, n_flush, n_rowsh, n_rdy, n_stall_m;

  function automatic logic [ROW_W-1:0] rowval(input int k);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*NB +: NB] = NB'(k * 37 + c * 11 + 5);
    return v;
  endfunction

  // Starts a frame of R rows and runs it cycle by cycle until done (or until
  // max_px pixels have been consumed). mode 0: always ready/valid; mode 1:
  // px_ready toggles; mode 2: random row_valid and px_ready. A start pulse
  // carrying alt_rows is driven at cycle start_at (0 = none).
  task automatic run_frame(input int R, input int mode, input int max_px,
                           input int start_at, input int alt_rows);
    logic [ROW_W-1:0] dq[$];
    logic [1:0]       pq[$];
    logic [ROW_W-1:0] ed;
    logic [1:0]       ep;
    bit               fin;
    int               nsh;
    fin = 0;
    for (int i = 0; i < R; i++) dq.push_back(rowval(i));
    if (R > 0) for (int i = 0; i < NR - 1; i++) dq.push_back('0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < NC; c++) pq.push_back({c == NC - 1, r == R - 1});
    first_px = -1; done_cyc = -1; n_done = 0; n_px = 0; n_rst = 0;
    n_acc = 0; n_flush = 0; n_rowsh = 0; n_rdy = 0; n_stall_m = 0;

    @(negedge clk);
    start = 1'b1; frame_rows = FRW'(R); row_valid = 1'b1; px_ready = 1'b1;
    row_data = rowval(0);
    @(posedge clk);
    for (int t = 1; t <= BOUND && !fin; t++) begin
      @(negedge clk);
      start = (t == start_at);
      if (start) frame_rows = FRW'(alt_rows);
      case (mode)
        1: begin row_valid = 1'b1; px_ready = (t % 2 == 1); end
        2: begin row_valid = 1'($urandom_range(0, 1)); px_ready = 1'($urandom_range(0, 1)); end
        default: begin row_valid = 1'b1; px_ready = 1'b1; end
      endcase
      row_data = rowval(n_acc);
      #1;
      if (rf_reset) n_rst++;
      if (row_ready) n_rdy++;
      if (row_ready && !row_valid) n_stall_m++;
      if (px_valid && !px_ready) n_stall_m++;

      n_total++;
      if (busy !== 1'b1) $display("FAIL busy_in_frame t=%0d got %b want 1", t, busy);
      else n_pass++;

      nsh = int'(rf_reset) + int'(rf_rowShift) + int'(rf_colShift);
      n_total++;
      if (nsh > 1) $display("FAIL ctrl_exclusive t=%0d got rst=%b row=%b col=%b want at most one",
                            t, rf_reset, rf_rowShift, rf_colShift);
      else n_pass++;

      n_total++;
      if (rf_colShift !== (px_valid && px_ready))
        $display("FAIL colshift_gate t=%0d got %b want %b", t, rf_colShift, px_valid && px_ready);
      else n_pass++;

      if (rf_rowShift) begin
        n_rowsh++;
        if (row_ready && row_valid) n_acc++; else n_flush++;
        n_total++;
        if (dq.size() == 0) begin
          $display("FAIL extra_rowshift t=%0d got rowShift=1 want no more shifts", t);
        end else begin
          ed = dq.pop_front();
          if (rf_data !== ed) $display("FAIL rf_data t=%0d got %h want %h", t, rf_data, ed);
          else n_pass++;
        end
      end

      if (px_valid) begin
        if (first_px < 0) first_px = t;
        if (px_ready) begin
          n_px++;
          n_total++;
          if (pq.size() == 0) begin
            $display("FAIL extra_pixel t=%0d got px handshake want none", t);
          end else begin
            ep = pq.pop_front();
            if ({px_last_col, px_last_row} !== ep)
              $display("FAIL px_flags px=%0d got col=%b row=%b want col=%b row=%b",
                       n_px, px_last_col, px_last_row, ep[1], ep[0]);
            else n_pass++;
          end
        end
      end

      if (done) begin n_done++; done_cyc = t; fin = 1; end
      if (max_px > 0 && n_px >= max_px) fin = 1;
    end
    start = 1'b0;
    n_total++;
    if (!fin) $display("FAIL frame_timeout got no done in %0d cycles want done", BOUND);
    else n_pass++;
    if (max_px == 0) begin
      n_total++;
      if (dq.size() != 0 || pq.size() != 0)
        $display("FAIL scoreboard_left got rows=%0d px=%0d want 0 0", dq.size(), pq.size());
      else n_pass++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_total++;
    if ({row_ready, rf_reset, rf_colShift, rf_rowShift, px_valid, px_last_col,
         px_last_row, busy, done} !== 9'b0 || rf_data !== '0 || stall_cycles !== 32'd0)
      $display("FAIL %s got ctrl=%b data=%h stall=%0d want all 0", tag,
               {row_ready, rf_reset, rf_colShift, rf_rowShift, px_valid, px_last_col,
                px_last_row, busy, done}, rf_data, stall_cycles);
    else n_pass++;
  endtask

  task automatic check_stall(input string tag);
    n_total++;
`ifdef RF2D_SEQ_PERF_EN
    if (stall_cycles !== 32'(n_stall_m))
      $display("FAIL %s got %0d want %0d", tag, stall_cycles, n_stall_m);
    else n_pass++;
`else
    if (stall_cycles !== 32'd0) $display("FAIL %s got %0d want 0", tag, stall_cycles);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; frame_rows = '0; row_data = rowval(3);
    row_valid = 1'b1; px_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero("reset_held");
    reset = 1'b1;
    @(negedge clk); #1;
    check_outputs_zero("idle_after_reset");
  endtask

  task automatic test_full_frame();
    run_frame(20, 0, 0, 0, 0);
    n_total++; if (first_px != 18) $display("FAIL first_px got %0d want 18", first_px); else n_pass++;
    n_total++; if (n_px != 360) $display("FAIL px_count got %0d want 360", n_px); else n_pass++;
    n_total++; if (n_acc != 20) $display("FAIL rows_accepted got %0d want 20", n_acc); else n_pass++;
    n_total++; if (n_flush != 15) $display("FAIL flushes got %0d want 15", n_flush); else n_pass++;
    n_total++; if (n_rowsh != 35) $display("FAIL rowshifts got %0d want 35", n_rowsh); else n_pass++;
    n_total++; if (n_rst != 1) $display("FAIL rf_reset_cycles got %0d want 1", n_rst); else n_pass++;
    // CLEAR 1 + FILL 16 + SCAN 360 + ADVANCE 19 cycles precede the DONE cycle.
    n_total++; if (done_cyc != 397) $display("FAIL done_cycle got %0d want 397", done_cyc); else n_pass++;
    check_stall("stall_full");
    @(negedge clk); #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_done got busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_short_frame();
    run_frame(4, 0, 0, 0, 0);
    n_total++; if (n_acc != 4) $display("FAIL short_accepted got %0d want 4", n_acc); else n_pass++;
    n_total++; if (n_flush != 15) $display("FAIL short_flushes got %0d want 15", n_flush); else n_pass++;
    n_total++; if (n_px != 72) $display("FAIL short_px got %0d want 72", n_px); else n_pass++;
    n_total++; if (done_cyc != 93) $display("FAIL short_done got %0d want 93", done_cyc); else n_pass++;
  endtask

  task automatic test_zero_rows();
    run_frame(0, 0, 0, 0, 0);
    n_total++; if (n_rdy != 0) $display("FAIL zero_row_ready got %0d want 0", n_rdy); else n_pass++;
    n_total++; if (first_px != -1) $display("FAIL zero_px_valid got cycle %0d want none", first_px); else n_pass++;
    n_total++; if (done_cyc != 2) $display("FAIL zero_done got %0d want 2", done_cyc); else n_pass++;
    n_total++; if (n_rst != 1) $display("FAIL zero_rf_reset got %0d want 1", n_rst); else n_pass++;
  endtask

  task automatic test_backpressure();
    run_frame(16, 1, 0, 0, 0);
    n_total++; if (n_px != 288) $display("FAIL bp_px got %0d want 288", n_px); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL bp_done got %0d want 1", n_done); else n_pass++;
    check_stall("stall_bp");
  endtask

  task automatic test_reset_mid_scan();
    run_frame(16, 0, 7, 0, 0);
    @(negedge clk); #1;
    n_total++; if (px_valid !== 1'b1 || px_last_col !== 1'b0)
      $display("FAIL mid_scan_state got valid=%b last_col=%b want 1 0", px_valid, px_last_col);
    else n_pass++;
    #1 reset = 1'b0;
    #1;
    check_outputs_zero("async_reset_mid_scan");
    @(negedge clk); reset = 1'b1;
    #1;
    check_outputs_zero("idle_after_mid_reset");
    run_frame(2, 0, 0, 0, 0);
    n_total++; if (n_rst != 1) $display("FAIL restart_rf_reset got %0d want 1", n_rst); else n_pass++;
    n_total++; if (n_px != 36) $display("FAIL restart_px got %0d want 36", n_px); else n_pass++;
    n_total++; if (done_cyc != 55) $display("FAIL restart_done got %0d want 55", done_cyc); else n_pass++;
  endtask

  task automatic test_start_ignored();
    run_frame(3, 0, 0, 25, 9);
    n_total++; if (n_px != 54) $display("FAIL ign_px got %0d want 54", n_px); else n_pass++;
    n_total++; if (n_acc != 3) $display("FAIL ign_accepted got %0d want 3", n_acc); else n_pass++;
    n_total++; if (n_done != 1) $display("FAIL ign_done got %0d want 1", n_done); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL ign_idle got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_frame(6, 2, 0, 0, 0);
    n_total++; if (n_acc != 6 || n_px != 108)
      $display("FAIL b2b_a got acc=%0d px=%0d want 6 108", n_acc, n_px); else n_pass++;
    check_stall("stall_b2b_a");
    run_frame(17, 2, 0, 0, 0);
    n_total++; if (n_acc != 17 || n_flush != 15 || n_px != 306)
      $display("FAIL b2b_b got acc=%0d flush=%0d px=%0d want 17 15 306", n_acc, n_flush, n_px);
    else n_pass++;
    check_stall("stall_b2b_b");
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_zero_rows();
    test_backpressure();
    test_reset_mid_scan();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
